// File: rtl/dil_sign_feeder.sv
// dil_sign_feeder
// Streams the packed secret key and message into a dilithium core running SIGN.
// After an accepted start pulse the block walks the segment order selected by
// HIGH_PERF, reads sk/msg words from a word-addressed buffer (1-cycle read
// latency) and presents them on a valid/ready stream at one word per cycle.
// The MLEN segment is a single synthesised word (msg_len zero-extended).
//
// Optional feature: define DIL_FEEDER_STALL_CNT_EN to add the stall_cycles
// output, a saturating count of busy cycles with valid_o && !ready_i.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle request, ignored unless idle
//   sk_base, msg_base     word addresses of packed sk and message
//   msg_len               message length in bytes
//   mem_rd_en/addr/data   read port, data valid one cycle after mem_rd_en
//   core_start            one-cycle start pulse to the core
//   valid_o/ready_i/data_o  output stream
//   busy, done            run in progress / end-of-run pulse
//   stall_cycles          (DIL_FEEDER_STALL_CNT_EN only) stall counter
module dil_sign_feeder #(
  parameter int unsigned W         = 64,
  parameter int unsigned AW        = 16,
  parameter int unsigned SEC_LEVEL = 2,
  parameter int unsigned HIGH_PERF = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] sk_base,
  input  logic [AW-1:0] msg_base,
  input  logic [31:0]   msg_len,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [W-1:0]  mem_rd_data,
  output logic          core_start,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [W-1:0]  data_o,
  output logic          busy,
  output logic          done
`ifdef DIL_FEEDER_STALL_CNT_EN
  ,
  output logic [31:0]   stall_cycles
`endif
);

  localparam int unsigned SeedW  = 256 / W;
  localparam int unsigned S1Bits = (SEC_LEVEL == 2) ? 3072 : (SEC_LEVEL == 3) ? 5120 : 5376;
  localparam int unsigned S2Bits = (SEC_LEVEL == 2) ? 3072 : 6144;
  localparam int unsigned T0Bits = (SEC_LEVEL == 2) ? 13312 : (SEC_LEVEL == 3) ? 19968 : 26624;
  localparam int unsigned S1W    = S1Bits / W;
  localparam int unsigned S2W    = S2Bits / W;
  localparam int unsigned T0W    = T0Bits / W;
  localparam int unsigned OffK   = SeedW;
  localparam int unsigned OffTr  = 2 * SeedW;
  localparam int unsigned OffS1  = 3 * SeedW;
  localparam int unsigned OffS2  = OffS1 + S1W;
  localparam int unsigned OffT0  = OffS2 + S2W;
  localparam int unsigned LogW   = $clog2(W);
  // Wide enough for ceil(8 * 2^32 / W) message words at any legal W.
  localparam int unsigned CntW   = 36;

  typedef enum logic [1:0] {StIdle, StSeg, StDrain} state_e;
  typedef enum logic [2:0] {
    SegRho, SegK, SegTr, SegS1, SegS2, SegT0, SegMlen, SegMsg
  } seg_e;

  // Maps the running segment index to the segment it stands for.
  function automatic seg_e seg_at(input logic [2:0] idx);
    seg_e s;
    if (HIGH_PERF != 0) begin
      case (idx)
        3'd0:    s = SegRho;
        3'd1:    s = SegMlen;
        3'd2:    s = SegTr;
        3'd3:    s = SegMsg;
        3'd4:    s = SegK;
        3'd5:    s = SegS1;
        3'd6:    s = SegS2;
        default: s = SegT0;
      endcase
    end else begin
      case (idx)
        3'd0:    s = SegRho;
        3'd1:    s = SegK;
        3'd2:    s = SegTr;
        3'd3:    s = SegS1;
        3'd4:    s = SegS2;
        3'd5:    s = SegT0;
        3'd6:    s = SegMlen;
        default: s = SegMsg;
      endcase
    end
    return s;
  endfunction

  state_e          state_q, state_d;
  logic [2:0]      seg_idx_q, seg_idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [AW-1:0]   sk_base_q, msg_base_q;
  logic [31:0]     msg_len_q;
  logic [CntW-1:0] msg_words_q;
  logic            core_start_q, core_start_d;
  logic            done_q, done_d;
  logic            infl_q, infl_mlen_q;
  logic [W-1:0]    fifo_q [2];
  logic            wr_ptr_q, rd_ptr_q;
  logic [1:0]      fifo_cnt_q, fifo_cnt_d;

  seg_e            seg;
  logic [CntW-1:0] seg_len;
  logic [AW-1:0]   seg_base;
  logic [AW-1:0]   rd_addr_calc;
  logic [CntW-1:0] msg_bits;
  logic [CntW-1:0] msg_words_raw;
  logic [CntW-1:0] msg_words_calc;
  logic [2:0]      occ_after;
  logic            accept, issue, last_word, pop, push;
  logic [W-1:0]    push_data;
  logic [W-1:0]    mlen_word;

  assign accept = (state_q == StIdle) && start;
  assign seg    = seg_at(seg_idx_q);

  always_comb begin
    seg_len = CntW'(SeedW);
    unique case (seg)
      SegRho, SegK, SegTr: seg_len = CntW'(SeedW);
      SegS1:               seg_len = CntW'(S1W);
      SegS2:               seg_len = CntW'(S2W);
      SegT0:               seg_len = CntW'(T0W);
      SegMlen:             seg_len = CntW'(1);
      SegMsg:              seg_len = msg_words_q;
      default:             seg_len = CntW'(1);
    endcase
  end

  always_comb begin
    seg_base = sk_base_q;
    unique case (seg)
      SegRho:  seg_base = sk_base_q;
      SegK:    seg_base = sk_base_q + AW'(OffK);
      SegTr:   seg_base = sk_base_q + AW'(OffTr);
      SegS1:   seg_base = sk_base_q + AW'(OffS1);
      SegS2:   seg_base = sk_base_q + AW'(OffS2);
      SegT0:   seg_base = sk_base_q + AW'(OffT0);
      SegMsg:  seg_base = msg_base_q;
      SegMlen: seg_base = '0;
      default: seg_base = '0;
    endcase
  end

  assign rd_addr_calc = seg_base + AW'(cnt_q);

  // msg words = max(1, ceil(8 * msg_len / W)); W is a power of two.
  assign msg_bits       = {1'b0, msg_len, 3'b000};
  assign msg_words_raw  = (msg_bits + CntW'(W - 1)) >> LogW;
  assign msg_words_calc = (msg_words_raw == '0) ? CntW'(1) : msg_words_raw;

  // Output stream straight from the FIFO head.
  assign valid_o = (fifo_cnt_q != 2'd0);
  assign data_o  = fifo_q[rd_ptr_q];
  assign pop     = valid_o && ready_i;
  assign push    = infl_q;

  // Credit counts the entry leaving this cycle so a stream at full rate never
  // bubbles, while buffered + in-flight words stay within the 2 FIFO slots.
  assign occ_after = {1'b0, fifo_cnt_q} + {2'b00, infl_q} - {2'b00, pop};
  assign issue     = (state_q == StSeg) && (occ_after < 3'd2);
  assign last_word = (cnt_q == seg_len - CntW'(1));

  // MLEN takes a FIFO slot through the in-flight stage but never touches memory.
  assign mem_rd_en   = issue && (seg != SegMlen);
  assign mem_rd_addr = mem_rd_en ? rd_addr_calc : '0;

  assign mlen_word = W'(msg_len_q);
  assign push_data = infl_mlen_q ? mlen_word : mem_rd_data;

  assign core_start = core_start_q;
  assign busy       = (state_q != StIdle);
  assign done       = done_q;

  always_comb begin
    state_d      = state_q;
    seg_idx_d    = seg_idx_q;
    cnt_d        = cnt_q;
    core_start_d = 1'b0;
    done_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StSeg;
          seg_idx_d    = 3'd0;
          cnt_d        = '0;
          core_start_d = 1'b1;
        end
      end
      StSeg: begin
        if (issue) begin
          if (last_word) begin
            cnt_d = '0;
            if (seg_idx_q == 3'd7) begin
              state_d = StDrain;
            end else begin
              seg_idx_d = seg_idx_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StDrain: begin
        // Last word is the sole remaining entry and is being accepted.
        if (!infl_q && (fifo_cnt_q == 2'd1) && pop) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      seg_idx_q    <= 3'd0;
      cnt_q        <= '0;
      core_start_q <= 1'b0;
      done_q       <= 1'b0;
      sk_base_q    <= '0;
      msg_base_q   <= '0;
      msg_len_q    <= '0;
      msg_words_q  <= CntW'(1);
      infl_q       <= 1'b0;
      infl_mlen_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      seg_idx_q    <= seg_idx_d;
      cnt_q        <= cnt_d;
      core_start_q <= core_start_d;
      done_q       <= done_d;
      infl_q       <= issue;
      infl_mlen_q  <= issue && (seg == SegMlen);
      if (accept) begin
        sk_base_q   <= sk_base;
        msg_base_q  <= msg_base;
        msg_len_q   <= msg_len;
        msg_words_q <= msg_words_calc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= push_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

`ifdef DIL_FEEDER_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if (busy && valid_o && !ready_i && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_dil_sign_feeder.sv
// Self-checking bench for dil_sign_feeder: three parameterisations
// (L2/high-perf, L5/low-res, L3/high-perf) driven by directed runs.
module tb_dil_sign_feeder;

  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  start_v, ready_v, rd_en_v, cs_v, valid_v, busy_v, done_v;
  logic [15:0] skb_v   [3];
  logic [15:0] msgb_v  [3];
  logic [15:0] addr_v  [3];
  logic [31:0] mlen_v  [3];
  logic [63:0] rdata_v [3];
  logic [63:0] data_v  [3];
`ifdef DIL_FEEDER_STALL_CNT_EN
  logic [31:0] stall_v [3];
`endif

  int checks = 0;
  int errors = 0;
  logic [64:0] exp_q [$];
  logic [63:0] word4;

  dil_sign_feeder #(.W(64), .AW(16), .SEC_LEVEL(2), .HIGH_PERF(1)) u_l2hp (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sk_base(skb_v[0]),
    .msg_base(msgb_v[0]), .msg_len(mlen_v[0]), .mem_rd_en(rd_en_v[0]),
    .mem_rd_addr(addr_v[0]), .mem_rd_data(rdata_v[0]), .core_start(cs_v[0]),
    .valid_o(valid_v[0]), .ready_i(ready_v[0]), .data_o(data_v[0]),
    .busy(busy_v[0]), .done(done_v[0])
`ifdef DIL_FEEDER_STALL_CNT_EN
    , .stall_cycles(stall_v[0])
`endif
  );

  dil_sign_feeder #(.W(64), .AW(16), .SEC_LEVEL(5), .HIGH_PERF(0)) u_l5lr (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sk_base(skb_v[1]),
    .msg_base(msgb_v[1]), .msg_len(mlen_v[1]), .mem_rd_en(rd_en_v[1]),
    .mem_rd_addr(addr_v[1]), .mem_rd_data(rdata_v[1]), .core_start(cs_v[1]),
    .valid_o(valid_v[1]), .ready_i(ready_v[1]), .data_o(data_v[1]),
    .busy(busy_v[1]), .done(done_v[1])
`ifdef DIL_FEEDER_STALL_CNT_EN
    , .stall_cycles(stall_v[1])
`endif
  );

  dil_sign_feeder #(.W(64), .AW(16), .SEC_LEVEL(3), .HIGH_PERF(1)) u_l3hp (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sk_base(skb_v[2]),
    .msg_base(msgb_v[2]), .msg_len(mlen_v[2]), .mem_rd_en(rd_en_v[2]),
    .mem_rd_addr(addr_v[2]), .mem_rd_data(rdata_v[2]), .core_start(cs_v[2]),
    .valid_o(valid_v[2]), .ready_i(ready_v[2]), .data_o(data_v[2]),
    .busy(busy_v[2]), .done(done_v[2])
`ifdef DIL_FEEDER_STALL_CNT_EN
    , .stall_cycles(stall_v[2])
`endif
  );

  // Unique, address-derived memory contents.
  function automatic logic [63:0] mem_word(input logic [15:0] a);
    return {a, ~a, a + 16'h1234, 16'hC0DE};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_mem
    always @(posedge clk) begin
      if (rd_en_v[g]) rdata_v[g] <= mem_word(addr_v[g]);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_mem(input logic [15:0] base, input int n);
    for (int j = 0; j < n; j++) exp_q.push_back({1'b1, mem_word(base + 16'(j))});
  endtask

  // Expected stream from the segment tables (W=64: seed segments are 4 words).
  task automatic build_exp(input int lvl, input bit hp, input logic [15:0] skb,
                           input logic [15:0] msgb, input logic [31:0] mlen);
    int s1w, s2w, t0w, msgw;
    int order [8];
    exp_q.delete();
    s1w  = (lvl == 2) ? 48 : (lvl == 3) ? 80 : 84;
    s2w  = (lvl == 2) ? 48 : 96;
    t0w  = (lvl == 2) ? 208 : (lvl == 3) ? 312 : 416;
    msgw = (mlen == 0) ? 1 : int'((mlen * 8 + 63) / 64);
    if (hp) order = '{0, 6, 2, 7, 1, 3, 4, 5};
    else    order = '{0, 1, 2, 3, 4, 5, 6, 7};
    for (int i = 0; i < 8; i++) begin
      case (order[i])
        0: push_mem(skb, 4);
        1: push_mem(skb + 16'd4, 4);
        2: push_mem(skb + 16'd8, 4);
        3: push_mem(skb + 16'd12, s1w);
        4: push_mem(skb + 16'd12 + 16'(s1w), s2w);
        5: push_mem(skb + 16'd12 + 16'(s1w) + 16'(s2w), t0w);
        6: exp_q.push_back({1'b0, 32'h0, mlen});
        default: push_mem(msgb, msgw);
      endcase
    end
  endtask

  // mode 0: ready high; 1: random ready; 2: ready low 20 cycles once idx==stall_at.
  task automatic run_stream(input int d, input int mode, input int stall_at,
                            input bit repulse, input string nm);
    int n, cyc, idx, first_valid, last_xfer, done_cyc, done_cnt, cs_cnt;
    int stalls, stall_rem, budget, rd_cnt, mem_xfer, max_out;
    logic prev_stall, rdy;
    logic [63:0] prev_data;
    logic [15:0] skb;
    logic [31:0] mlen;
    n = exp_q.size();
    idx = 0; first_valid = -1; last_xfer = -1; done_cyc = -1; done_cnt = 0;
    cs_cnt = 0; stalls = 0; stall_rem = 20; rd_cnt = 0; mem_xfer = 0; max_out = 0;
    prev_stall = 1'b0; prev_data = '0; word4 = '1;
    skb = skb_v[d]; mlen = mlen_v[d];
    budget = 4 * n + 100;
    @(posedge clk); #1;
    start_v[d] = 1'b1;
    ready_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    cyc = 1;
    while (cyc <= budget && (done_cyc < 0 || cyc <= done_cyc + 3)) begin
      case (mode)
        1: rdy = 1'($urandom_range(0, 1));
        2: begin
          rdy = 1'b1;
          if (idx == stall_at && stall_rem > 0) begin
            rdy = 1'b0;
            stall_rem--;
          end
        end
        default: rdy = 1'b1;
      endcase
      ready_v[d] = rdy;
      if (repulse && cyc == 10) begin
        start_v[d] = 1'b1;
        skb_v[d]   = ~skb;
        mlen_v[d]  = 32'hFFFF;
      end else if (repulse && cyc == 11) begin
        start_v[d] = 1'b0;
        skb_v[d]   = skb;
        mlen_v[d]  = mlen;
      end
      @(negedge clk);
      if (cyc == 1) begin
        check({nm, " core_start t+1"}, 64'(cs_v[d]), 64'd1);
        check({nm, " busy t+1"}, 64'(busy_v[d]), 64'd1);
        check({nm, " rd_en t+1"}, 64'(rd_en_v[d]), 64'd1);
        check({nm, " rd_addr t+1"}, 64'(addr_v[d]), 64'(skb));
      end
      if (cs_v[d]) cs_cnt++;
      if (prev_stall) begin
        check({nm, " valid held in stall"}, 64'(valid_v[d]), 64'd1);
        check({nm, " data held in stall"}, data_v[d], prev_data);
      end
      if (rd_en_v[d]) rd_cnt++;
      if (valid_v[d] && first_valid < 0) first_valid = cyc;
      if (valid_v[d] && ready_v[d]) begin
        if (idx < n) begin
          check($sformatf("%s word %0d", nm, idx), data_v[d], exp_q[idx][63:0]);
          if (exp_q[idx][64]) mem_xfer++;
        end else begin
          check({nm, " word count overrun"}, 64'(idx + 1), 64'(n));
        end
        if (idx == 4) word4 = data_v[d];
        idx++;
        last_xfer = cyc;
      end
      if (rd_cnt - mem_xfer > max_out) max_out = rd_cnt - mem_xfer;
      if (busy_v[d] && valid_v[d] && !ready_v[d]) stalls++;
      prev_stall = valid_v[d] && !ready_v[d];
      prev_data  = data_v[d];
      if (done_v[d]) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        check({nm, " busy low at done"}, 64'(busy_v[d]), 64'd0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    start_v[d] = 1'b0;
    ready_v[d] = 1'b1;
    check({nm, " done count"}, 64'(done_cnt), 64'd1);
    check({nm, " words transferred"}, 64'(idx), 64'(n));
    check({nm, " first valid at t+3"}, 64'(first_valid), 64'd3);
    check({nm, " core_start count"}, 64'(cs_cnt), 64'd1);
    check({nm, " done after last xfer"}, 64'(done_cyc), 64'(last_xfer + 1));
    check({nm, " outstanding <= 2"}, 64'(max_out <= 2), 64'd1);
    if (mode == 0) begin
      check({nm, " last xfer at t+2+N"}, 64'(last_xfer), 64'(n + 2));
      check({nm, " done at t+3+N"}, 64'(done_cyc), 64'(n + 3));
      check({nm, " no stalls"}, 64'(stalls), 64'd0);
    end
    if (mode == 2) check({nm, " stall cycles"}, 64'(stalls), 64'd20);
`ifdef DIL_FEEDER_STALL_CNT_EN
    check({nm, " stall_cycles"}, 64'(stall_v[d]), 64'(stalls));
`endif
  endtask

  initial begin
    int idx;
    rst_n   = 1'b0;
    start_v = 3'b000;
    ready_v = 3'b111;
    for (int i = 0; i < 3; i++) begin
      skb_v[i]  = 16'h0;
      msgb_v[i] = 16'h0;
      mlen_v[i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset rd_en", 64'(rd_en_v[0]), 64'd0);
    check("reset rd_addr", 64'(addr_v[0]), 64'd0);
    check("reset core_start", 64'(cs_v[0]), 64'd0);
    check("reset valid", 64'(valid_v[0]), 64'd0);
    check("reset data", data_v[0], 64'd0);
    check("reset busy", 64'(busy_v[0]), 64'd0);
    check("reset done", 64'(done_v[0]), 64'd0);
    check("reset valid l5", 64'(valid_v[1]), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // L2 high-perf, msg_len=33, start re-pulsed at t+10 with altered inputs.
    skb_v[0] = 16'h0100; msgb_v[0] = 16'h4000; mlen_v[0] = 32'd33;
    build_exp(2, 1'b1, 16'h0100, 16'h4000, 32'd33);
    run_stream(0, 0, 0, 1'b1, "l2hp");
    check("l2hp mlen word", word4, 64'h21);

    // L5 low-res, empty message.
    skb_v[1] = 16'h0800; msgb_v[1] = 16'h9000; mlen_v[1] = 32'd0;
    build_exp(5, 1'b0, 16'h0800, 16'h9000, 32'd0);
    run_stream(1, 0, 0, 1'b0, "l5lr");

    // L3 high-perf under random backpressure.
    skb_v[2] = 16'h1000; msgb_v[2] = 16'hA000; mlen_v[2] = 32'd20;
    build_exp(3, 1'b1, 16'h1000, 16'hA000, 32'd20);
    run_stream(2, 1, 0, 1'b0, "l3rnd");

    // L2 stall of 20 cycles at the TR->MSG boundary (MSG starts at word 9).
    skb_v[0] = 16'h0200; msgb_v[0] = 16'h5000; mlen_v[0] = 32'd33;
    build_exp(2, 1'b1, 16'h0200, 16'h5000, 32'd33);
    run_stream(0, 2, 9, 1'b0, "l2stall");

    // Reset mid-S1 with the FIFO full, then a fresh run.
    skb_v[0] = 16'h0300; msgb_v[0] = 16'h6000; mlen_v[0] = 32'd33;
    build_exp(2, 1'b1, 16'h0300, 16'h6000, 32'd33);
    @(posedge clk); #1;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    idx = 0;
    for (int c = 0; c < 200 && idx < 20; c++) begin
      ready_v[0] = 1'b1;
      @(negedge clk);
      if (valid_v[0]) begin
        check($sformatf("rst pre word %0d", idx), data_v[0], exp_q[idx][63:0]);
        idx++;
      end
      @(posedge clk); #1;
    end
    check("rst reached mid-s1", 64'(idx), 64'd20);
    ready_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst buffered valid", 64'(valid_v[0]), 64'd1);
    check("rst no read when full", 64'(rd_en_v[0]), 64'd0);
    check("rst head word", data_v[0], exp_q[20][63:0]);
    rst_n = 1'b0;
    #1;
    check("midrst rd_en", 64'(rd_en_v[0]), 64'd0);
    check("midrst rd_addr", 64'(addr_v[0]), 64'd0);
    check("midrst core_start", 64'(cs_v[0]), 64'd0);
    check("midrst valid", 64'(valid_v[0]), 64'd0);
    check("midrst data", data_v[0], 64'd0);
    check("midrst busy", 64'(busy_v[0]), 64'd0);
    check("midrst done", 64'(done_v[0]), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready_v[0] = 1'b1;
    run_stream(0, 0, 0, 1'b0, "l2after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
